// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: Funct3 encodings, FSM states
// and the access-size decode.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    RESP = 2'd3
  } lsu_state_t;

  // Bytes touched by an access; unknown encodings fall back to a full word.
  function automatic logic [2:0] access_size(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: access_size = 3'd1;
      F3_H, F3_HU: access_size = 3'd2;
      default:     access_size = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Pipeline request/response and data-memory port of the load/store unit.
// master = the LSU itself, slave = MEM stage plus data memory.
interface lsu_if #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  MemRead;
  logic                  MemWrite;
  logic [2:0]            Funct3;
  logic [DM_ADDRESS-1:0] addr;
  logic [DATA_W-1:0]     wdata;
  logic                  resp_valid;
  logic [DATA_W-1:0]     rd;
  logic                  misaligned;
  logic [DM_ADDRESS-1:0] mem_a;
  logic                  mem_we;
  logic [3:0]            mem_be;
  logic [DATA_W-1:0]     mem_wd;
  logic [DATA_W-1:0]     mem_rd;

  modport master (
    input  req_valid, MemRead, MemWrite, Funct3, addr, wdata, mem_rd,
    output req_ready, resp_valid, rd, misaligned, mem_a, mem_we, mem_be, mem_wd
  );

  modport slave (
    output req_valid, MemRead, MemWrite, Funct3, addr, wdata, mem_rd,
    input  req_ready, resp_valid, rd, misaligned, mem_a, mem_we, mem_be, mem_wd
  );
endinterface

// File: rtl/lsu_load_align.sv
// Load result alignment: shifts the {hi,lo} word pair down by the byte offset,
// truncates to the access size and sign/zero extends to DATA_W.
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2*DATA_W-1:0] word_pair,
  input  logic [1:0]          off,
  input  logic [2:0]          funct3,
  output logic [DATA_W-1:0]   rd
);
  logic [DATA_W-1:0] shifted;

  always_comb begin
    shifted = DATA_W'(word_pair >> {off, 3'b000});
    case (funct3)
      F3_B:    rd = {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
      F3_H:    rd = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
      F3_BU:   rd = {{(DATA_W-8){1'b0}}, shifted[7:0]};
      F3_HU:   rd = {{(DATA_W-16){1'b0}}, shifted[15:0]};
      default: rd = shifted;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one request in flight, word accesses with byte lanes.
// LSU_MISALIGN_SPLIT_EN: split word-crossing accesses in two; otherwise flag misaligned ones.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic    clk,
  input  logic    reset,
  lsu_if.master   bus
);
  lsu_state_t              state, state_nx;
  logic [DM_ADDRESS-1:0]   r_addr;
  logic [2:0]              r_f3;
  logic [DATA_W-1:0]       r_wdata;
  logic                    r_load, r_split, r_mis;
  logic [DATA_W-1:0]       lo_buf, rd_q, load_rd;
  logic [2:0]              req_size, size;
  logic [1:0]              off;
  logic                    accept, split_d, mis_d;
  logic [7:0]              lane_mask;
  logic [2*DATA_W-1:0]     wd_pair, word_pair;
  logic [DM_ADDRESS-3:0]   word_nx;

  assign req_size = access_size(bus.Funct3);
  assign accept   = (state == IDLE) && bus.req_valid && (bus.MemRead || bus.MemWrite);

`ifdef LSU_MISALIGN_SPLIT_EN
  logic req_cross;
  assign req_cross = ({1'b0, bus.addr[1:0]} + req_size) > 3'd4;
  assign split_d   = req_cross;
  assign mis_d     = 1'b0;
`else
  logic req_mis;
  assign req_mis = ({1'b0, bus.addr[1:0]} & (req_size - 3'd1)) != 3'd0;
  assign split_d = 1'b0;
  assign mis_d   = req_mis;
`endif

  assign size = access_size(r_f3);
  assign off  = r_addr[1:0];
  // Low nibble = lanes of the first word, high nibble = spill-over lanes of the next.
  assign lane_mask = ((8'd1 << size) - 8'd1) << off;
  assign wd_pair   = {{DATA_W{1'b0}}, r_wdata} << {off, 3'b000};
  assign word_pair = r_split ? {bus.mem_rd, lo_buf} : {{DATA_W{1'b0}}, bus.mem_rd};
  assign word_nx   = r_addr[DM_ADDRESS-1:2] + {{(DM_ADDRESS-3){1'b0}}, 1'b1};

  lsu_load_align #(.DATA_W(DATA_W)) u_align (
    .word_pair (word_pair),
    .off       (off),
    .funct3    (r_f3),
    .rd        (load_rd)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      r_addr  <= '0;
      r_f3    <= '0;
      r_wdata <= '0;
      r_load  <= 1'b0;
      r_split <= 1'b0;
      r_mis   <= 1'b0;
      lo_buf  <= '0;
      rd_q    <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        r_addr  <= bus.addr;
        r_f3    <= bus.Funct3;
        r_wdata <= bus.wdata;
        r_load  <= bus.MemRead;
        r_split <= split_d;
        r_mis   <= mis_d;
      end
      if (state == ACC1) lo_buf <= bus.mem_rd;
      if (state == RESP && r_load && !r_mis) rd_q <= load_rd;
    end
  end

  always_comb begin
    state_nx       = state;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.misaligned = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_be     = 4'b0000;
    bus.mem_a      = {r_addr[DM_ADDRESS-1:2], 2'b00};
    bus.mem_wd     = '0;
    bus.rd         = rd_q;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (accept) state_nx = mis_d ? RESP : ACC0;
      end
      ACC0: begin
        bus.mem_we = !r_load;
        bus.mem_be = lane_mask[3:0];
        bus.mem_wd = wd_pair[DATA_W-1:0];
        state_nx   = r_split ? ACC1 : RESP;
      end
      ACC1: begin
        bus.mem_a  = {word_nx, 2'b00};
        bus.mem_we = !r_load;
        bus.mem_be = lane_mask[7:4];
        bus.mem_wd = wd_pair[2*DATA_W-1:DATA_W];
        state_nx   = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.misaligned = r_mis;
        // Final word arrives this cycle, so the response bypasses rd_q.
        if (r_load && !r_mis) bus.rd = load_rd;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Pipeline-side initiator for data memory. It accepts one load/store request per transaction from the MEM stage over a valid/ready handshake and drives word-aligned accesses with byte-lane enables onto the data-memory port. Load results are aligned and sign- or zero-extended to `DATA_W`. A misaligned access that crosses a word boundary is split into two word accesses by a small FSM, stalling the pipeline until the transaction completes.

## Interface
Parameters:
- `DM_ADDRESS`, 9, byte-address width of data memory
- `DATA_W`, 32, data width (fixed 4 byte lanes)

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock, rising edge
- `reset` in 1: asynchronous, active-high
- `req_valid` in 1: MEM-stage request present
- `req_ready` out 1: request accepted this cycle when both high
- `MemRead` in 1: load request
- `MemWrite` in 1: store request
- `Funct3` in 3: instruction bits 14:12
- `addr` in `DM_ADDRESS`: byte address (ALU result LSBs)
- `wdata` in `DATA_W`: store data
- `resp_valid` out 1: one-cycle pulse at transaction completion
- `rd` out `DATA_W`: extended load result, held until the next load response
- `misaligned` out 1: qualifies `resp_valid` (see Configuration)
- `mem_a` out `DM_ADDRESS`: word address, bits [1:0] = 0
- `mem_we` out 1: write strobe
- `mem_be` out 4: byte-lane enables
- `mem_wd` out `DATA_W`: lane-positioned write data
- `mem_rd` in `DATA_W`: read word, valid the cycle after `mem_a` is presented

## Operation
- Size: 000 LB/SB = 1 byte; 001 LH/SH = 2; 010 LW/SW = 4; 100 LBU = 1; 101 LHU = 2. All other encodings are treated as a word access.
- `off` = `addr[1:0]`. The access is split when `off` + size > 4.
- If `MemRead` and `MemWrite` are both high, the request is a read. A request with neither set is accepted and dropped: no response, no access.
- FSM states: IDLE, ACC0, ACC1, RESP.
- **IDLE**
  - `req_ready` = 1.
  - On handshake, latch the request and go to ACC0.
- **ACC0**
  - `mem_a` = word of `addr`.
  - `mem_be` = low-lane mask, i.e. ((1<<size)-1) << `off`, truncated to 4 bits.
  - `mem_wd` = `wdata` << 8·`off`.
  - `mem_we` = store.
  - Next state: ACC1 if split, else RESP.
- **ACC1**
  - Capture `mem_rd` into the low buffer.
  - `mem_a` = next word, wrapping modulo 2^`DM_ADDRESS` (the top word wraps to 0).
  - `mem_be` = remaining upper lanes starting at lane 0.
  - `mem_wd` = `wdata` >> 8·(4−`off`).
- **RESP**
  - Capture the final `mem_rd`.
  - Loads: `rd` = ({hi,lo} >> 8·`off`), truncated to size, then extended (sign for LB/LH, zero for LBU/LHU).
  - `resp_valid` = 1 for one cycle, then go to IDLE.
- Stores do not update `rd`.
- Outside ACC0/ACC1: `mem_we` = 0, `mem_be` = 0.

## Timing
- Reset values: state IDLE, `req_ready` = 1, `resp_valid` = 0, `rd` = 0, `misaligned` = 0, `mem_we` = 0, `mem_be` = 0, `mem_a` = 0, `mem_wd` = 0.
- Aligned or non-crossing access: handshake at cycle T, ACC0 at T+1, `resp_valid` at T+2.
- Split access: handshake at T, ACC0 at T+1, ACC1 at T+2, `resp_valid` at T+3.
- `req_ready` = 0 in ACC0, ACC1 and RESP, giving at most one transaction in flight. The next request can be accepted in the cycle after RESP.
- Reset mid-operation returns the FSM to IDLE immediately and deasserts `mem_we`/`mem_be` asynchronously. If the ACC0 half of a split store has already been written, it stays written.

## Configuration
- `LSU_MISALIGN_SPLIT_EN` defined: split behaviour as above; `misaligned` is tied to 0.
- Undefined: any access with `off` not a multiple of size goes IDLE→RESP with no memory access. `resp_valid` and `misaligned` = 1 at T+1, and `rd` is unchanged. Aligned accesses behave identically in both builds.

## Structure
- `lsu_pkg`:
  - `Funct3` constants (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - `lsu_state_t` enum
  - size-decode function
- Sub-module `lsu_load_align`: combinational {hi,lo}/`off`/`Funct3` → extended `rd`. Instantiated once in RESP datapath.

## Test plan
- LW at addr 0x010, memory word 0x8899AABB → `mem_be`=1111 at T+1, `rd`=0x8899AABB with `resp_valid` at T+2.
- LB at 0x013, word 0x80112233 → `rd`=0xFFFFFF80. LBU at the same address → `rd`=0x00000080.
- SH 0xBEEF at 0x012 → single access at T+1: `mem_a`=0x010, `mem_be`=1100, `mem_wd`=0xBEEF0000.
- With macro: LW at 0x1FE, words [0x1FC]=0xDDCCBBAA and [0x000]=0x44332211 → second `mem_a`=0x000, `rd`=0x2211DDCC at T+3.
- Without macro: LH at 0x003 → no `mem_be` activity; `resp_valid`=1 and `misaligned`=1 at T+1.
- Assert `reset` during ACC1 of a split SW → `mem_we` drops that cycle, `req_ready`=1 and `resp_valid`=0 after reset.
